mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-memory port.
- Sequences each access through an FSM and holds it until the memory acknowledges.
- Returns the read data together with a one-cycle valid pulse.
- Produces stall signals that the hazard logic uses to freeze the PC and the pipeline registers, and bounds every access with a timeout.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 16, max BUSY cycles waiting for mem_ready; 0 disables the timeout. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_funct3  in  3  access size/sign, forwarded unchanged
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_funct3  out  3  memory access size
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory acknowledge
- stall_if  out  1  combinational: if_req & ~if_valid
- stall_mem  out  1  combinational: dm_req & ~dm_valid
- err  out  1  one-cycle pulse, coincident with the valid pulse, on timeout

Behaviour:
- Reset:
  - All registered outputs go to 0 and the state goes to IDLE.
  - A reset asserted mid-access aborts the access: mem_req=0 after that edge, and no valid pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Sample requests; select owner by priority (dm over if by default).
  - On any request, latch owner, address, we, wdata and funct3 into registers, then go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_req=1 and all mem_* outputs driven from the latched registers, stable for the whole state.
  - mem_we is 0 when the owner is fetch.
  - Requester inputs are ignored until DONE.
  - If mem_ready=1: capture mem_rdata into the owner's rdata register (stores capture too, value don't-care), go to DONE.
  - Timeout counter: cleared on IDLE->BUSY, increments each BUSY cycle without ready. When it reaches TIMEOUT-1 with mem_ready=0, go to DONE with err flagged and rdata forced to 0.
  - If mem_ready arrives on that same cycle, ready wins and no err is raised.
- DONE:
  - mem_req=0, owner's valid=1, err=1 if flagged.
  - Always returns to IDLE next cycle.
  - DONE exists so a requester can retire its request before the next IDLE sample, which prevents re-granting a stale request.
- Timing:
  - Latency with mem_ready in the first BUSY cycle: request seen in IDLE at cycle n, mem_req at n+1, valid at n+2, IDLE at n+3.
  - Minimum occupancy is 3 cycles per access; there is no pipelining of accesses.
- Non-owner: its valid stays 0 and its stall stays asserted for as long as its request is high.
- Simultaneous if_req and dm_req in IDLE: the data port wins, the fetch waits. With fixed priority, fetch starvation is acceptable because data requests are bounded by the program.
- mem_ready outside BUSY is ignored.
- rdata registers hold their value until the next completion for that port.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register (reset value = fetch) is updated on each IDLE->BUSY transition.
  - When both requests are pending, grant goes to the port that was not last_owner.
  - A single request is granted regardless of last_owner.
- Undefined: fixed priority, dm over if; no last_owner register.

Test Plan:
- Reset, then if_req=1, if_addr=0x00000010, mem_ready=1 in the first BUSY cycle, mem_rdata=0x00A00093 -> mem_req high on cycle 1 only; if_valid=1 with if_rdata=0x00A00093 on cycle 2; stall_if=1 on cycles 0-1 and 0 on cycle 2; mem_we=0.
- if_req and dm_req both asserted on the same cycle, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready immediate -> first access has mem_addr=0x100, mem_we=1, mem_wdata=0xDEADBEEF; dm_valid pulses first; fetch granted next, if_valid 3 cycles after dm_valid. With MEM_ARB_RR_EN, after a prior data grant the fetch goes first instead.
- Load with mem_ready delayed 5 cycles, mem_rdata=0x12345678 -> mem_req high for 6 consecutive cycles with a stable address; dm_valid and dm_rdata=0x12345678 one cycle after ready; err=0.
- TIMEOUT=16, mem_ready never asserted -> mem_req high for exactly 16 cycles; then dm_valid=1, err=1, dm_rdata=0; FSM back in IDLE.
- Second case at the boundary: mem_ready=1 on the 16th BUSY cycle -> normal completion, err=0.
- reset pulsed during the 3rd BUSY cycle of a fetch -> mem_req=0 on the next cycle; if_valid never pulses; a new if_req after reset completes normally.
- Stale-request check: requester holds if_req through the if_valid cycle, then drops it -> exactly one memory access is issued, no duplicate grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and data-memory ports (IDLE/BUSY/DONE).
// Optional round-robin grant when both ports request: define MEM_ARB_RR_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              owner_dm;
    logic              grant_dm;
    logic              any_req;
    logic              timeout_hit;
    logic              finish;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap_data;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    // last_owner: 1 = data port, 0 = fetch; on contention the other port wins
    logic last_owner;

    assign grant_dm = dm_req & (~if_req | ~last_owner);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            last_owner <= grant_dm;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST)) && !mem_ready;
    assign finish      = mem_ready | timeout_hit;
    assign cap_data    = mem_ready ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_BUSY;
            S_BUSY:  if (finish)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_dm <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            cnt      <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_dm <= grant_dm;
                        addr_q   <= grant_dm ? dm_addr : if_addr;
                        we_q     <= grant_dm & dm_we;
                        wdata_q  <= dm_wdata;
                        funct3_q <= grant_dm ? dm_funct3 : FETCH_FUNCT3;
                        cnt      <= '0;
                    end
                end
                S_BUSY: begin
                    if (finish) begin
                        err <= timeout_hit;
                        if (owner_dm) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= cap_data;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= cap_data;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req    = (state == S_BUSY);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_funct3 = funct3_q;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, delayed ready, timeout, reset abort.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [2:0]    dm_funct3;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_funct3 = 3'b000; mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        next_cycle; next_cycle; sample;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_dm_valid", 64'(dm_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_dm_rdata", 64'(dm_rdata), 64'd0);
        next_cycle; reset = 1'b0;

        // Single fetch, ready in first BUSY cycle; request held through valid then dropped
        next_cycle; if_req = 1'b1; if_addr = 32'h0000_0010;
        sample;
        check("f_c0_mem_req", 64'(mem_req), 64'd0);
        check("f_c0_stall_if", 64'(stall_if), 64'd1);
        next_cycle; mem_ready = 1'b1; mem_rdata = 32'h00A0_0093;
        sample;
        check("f_c1_mem_req", 64'(mem_req), 64'd1);
        check("f_c1_mem_addr", 64'(mem_addr), 64'h10);
        check("f_c1_mem_we", 64'(mem_we), 64'd0);
        check("f_c1_stall_if", 64'(stall_if), 64'd1);
        next_cycle; mem_ready = 1'b0;
        sample;
        check("f_c2_if_valid", 64'(if_valid), 64'd1);
        check("f_c2_if_rdata", 64'(if_rdata), 64'h00A0_0093);
        check("f_c2_stall_if", 64'(stall_if), 64'd0);
        check("f_c2_mem_req", 64'(mem_req), 64'd0);
        next_cycle; if_req = 1'b0;
        sample;
        check("f_c3_mem_req", 64'(mem_req), 64'd0);
        check("f_c3_if_valid", 64'(if_valid), 64'd0);
        next_cycle; sample;
        check("f_c4_no_regrant", 64'(mem_req), 64'd0);

        // Simultaneous requests: store wins, fetch follows
        next_cycle;
        if_req = 1'b1; if_addr = 32'h0000_0020;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        dm_funct3 = 3'b001; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        sample;
        check("p_c0_mem_req", 64'(mem_req), 64'd0);
        next_cycle; sample;
        check("p_c1_mem_req", 64'(mem_req), 64'd1);
        check("p_c1_mem_addr", 64'(mem_addr), 64'h100);
        check("p_c1_mem_we", 64'(mem_we), 64'd1);
        check("p_c1_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("p_c1_mem_funct3", 64'(mem_funct3), 64'd1);
        next_cycle; sample;
        check("p_c2_dm_valid", 64'(dm_valid), 64'd1);
        check("p_c2_if_valid", 64'(if_valid), 64'd0);
        check("p_c2_stall_mem", 64'(stall_mem), 64'd0);
        check("p_c2_stall_if", 64'(stall_if), 64'd1);
        next_cycle; dm_req = 1'b0; dm_we = 1'b0;
        sample;
        check("p_c3_dm_valid", 64'(dm_valid), 64'd0);
        check("p_c3_mem_req", 64'(mem_req), 64'd0);
        next_cycle; sample;
        check("p_c4_mem_req", 64'(mem_req), 64'd1);
        check("p_c4_mem_addr", 64'(mem_addr), 64'h20);
        check("p_c4_mem_we", 64'(mem_we), 64'd0);
        next_cycle; sample;
        check("p_c5_if_valid", 64'(if_valid), 64'd1);
        check("p_c5_if_rdata", 64'(if_rdata), 64'hCAFE_F00D);
        next_cycle; if_req = 1'b0; mem_ready = 1'b0;
        sample;
        check("p_c6_mem_req", 64'(mem_req), 64'd0);

        // Load with ready arriving on the 6th BUSY cycle
        next_cycle;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_funct3 = 3'b000;
        mem_rdata = 32'h1234_5678;
        sample;
        for (int i = 1; i <= 6; i++) begin
            next_cycle; mem_ready = (i == 6);
            sample;
            check($sformatf("d_c%0d_mem_req", i), 64'(mem_req), 64'd1);
            check($sformatf("d_c%0d_mem_addr", i), 64'(mem_addr), 64'h200);
            check($sformatf("d_c%0d_dm_valid", i), 64'(dm_valid), 64'd0);
            check($sformatf("d_c%0d_stall_mem", i), 64'(stall_mem), 64'd1);
        end
        next_cycle; mem_ready = 1'b0;
        sample;
        check("d_c7_dm_valid", 64'(dm_valid), 64'd1);
        check("d_c7_dm_rdata", 64'(dm_rdata), 64'h1234_5678);
        check("d_c7_err", 64'(err), 64'd0);
        check("d_c7_mem_req", 64'(mem_req), 64'd0);
        next_cycle; dm_req = 1'b0;
        sample;
        check("d_c8_dm_valid", 64'(dm_valid), 64'd0);

        // Timeout: mem_ready never arrives
        next_cycle;
        dm_req = 1'b1; dm_addr = 32'h0000_0300; mem_rdata = 32'hFFFF_FFFF;
        sample;
        for (int i = 1; i <= 16; i++) begin
            next_cycle; sample;
            check($sformatf("t_c%0d_mem_req", i), 64'(mem_req), 64'd1);
        end
        next_cycle; sample;
        check("t_c17_mem_req", 64'(mem_req), 64'd0);
        check("t_c17_dm_valid", 64'(dm_valid), 64'd1);
        check("t_c17_err", 64'(err), 64'd1);
        check("t_c17_dm_rdata", 64'(dm_rdata), 64'd0);
        next_cycle; dm_req = 1'b0;
        sample;
        check("t_c18_err", 64'(err), 64'd0);
        check("t_c18_dm_valid", 64'(dm_valid), 64'd0);
        check("t_c18_mem_req", 64'(mem_req), 64'd0);

        // Boundary: ready on the 16th BUSY cycle wins over timeout
        next_cycle;
        dm_req = 1'b1; dm_addr = 32'h0000_0304; mem_rdata = 32'hA5A5_A5A5;
        sample;
        for (int i = 1; i <= 16; i++) begin
            next_cycle; mem_ready = (i == 16);
            sample;
            check($sformatf("b_c%0d_mem_req", i), 64'(mem_req), 64'd1);
        end
        next_cycle; mem_ready = 1'b0;
        sample;
        check("b_c17_dm_valid", 64'(dm_valid), 64'd1);
        check("b_c17_err", 64'(err), 64'd0);
        check("b_c17_dm_rdata", 64'(dm_rdata), 64'hA5A5_A5A5);
        next_cycle; dm_req = 1'b0;
        sample;

        // Reset during the 3rd BUSY cycle of a fetch aborts it
        next_cycle; if_req = 1'b1; if_addr = 32'h0000_0040;
        sample;
        next_cycle; sample;
        check("r_c1_mem_req", 64'(mem_req), 64'd1);
        next_cycle; sample;
        next_cycle; reset = 1'b1;
        sample;
        check("r_c3_mem_req", 64'(mem_req), 64'd1);
        next_cycle; reset = 1'b0; if_req = 1'b0;
        sample;
        check("r_c4_mem_req", 64'(mem_req), 64'd0);
        check("r_c4_if_valid", 64'(if_valid), 64'd0);
        check("r_c4_if_rdata", 64'(if_rdata), 64'd0);
        for (int i = 5; i <= 7; i++) begin
            next_cycle; sample;
            check($sformatf("r_c%0d_if_valid", i), 64'(if_valid), 64'd0);
            check($sformatf("r_c%0d_mem_req", i), 64'(mem_req), 64'd0);
        end
        next_cycle;
        if_req = 1'b1; if_addr = 32'h0000_0044; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        sample;
        next_cycle; sample;
        check("n_c1_mem_req", 64'(mem_req), 64'd1);
        check("n_c1_mem_addr", 64'(mem_addr), 64'h44);
        next_cycle; sample;
        check("n_c2_if_valid", 64'(if_valid), 64'd1);
        check("n_c2_if_rdata", 64'(if_rdata), 64'h13);
        next_cycle; if_req = 1'b0; mem_ready = 1'b0;
        sample;
        check("n_c3_if_valid", 64'(if_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
